// File: rtl/wall_pkg.sv
// wall_pkg: shared wall geometry constants, types and orientation-dependent wall sizes
package wall_pkg;
    typedef logic [9:0] coord_t;
    localparam coord_t OBJ_SIZE = 10'd16;
    localparam coord_t HOR_W    = 10'd64;
    localparam coord_t HOR_H    = 10'd32;
    localparam coord_t VERT_W   = 10'd32;
    localparam coord_t VERT_H   = 10'd64;
    localparam coord_t X_MAX    = 10'd639;
    localparam coord_t Y_MAX    = 10'd479;
    localparam int NUM_WALLS    = 4;
    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t w;
        coord_t h;
    } wall_rect_t;
    // walls 0 and 2 are horizontal, walls 1 and 3 vertical; origin left at zero
    function automatic wall_rect_t wall_dims(input logic [1:0] idx);
        wall_rect_t r;
        r.x = '0;
        r.y = '0;
        r.w = idx[0] ? VERT_W : HOR_W;
        r.h = idx[0] ? VERT_H : HOR_H;
        return r;
    endfunction
endpackage

// File: rtl/wall_collision_if.sv
// wall_collision_if: request/result bundle between motion logic and the collision checker
interface wall_collision_if;
    import wall_pkg::*;
    logic   Start;
    coord_t Next_X, Next_Y;
    coord_t X1, X2, X3, X4;
    coord_t Y1, Y2, Y3, Y4;
    logic   Busy;
    logic   Result_Valid;
    logic   Move_OK;
    logic [3:0] Hit_Mask;
    logic   Out_Of_Bounds;
    modport master (
        output Start, Next_X, Next_Y, X1, X2, X3, X4, Y1, Y2, Y3, Y4,
        input  Busy, Result_Valid, Move_OK, Hit_Mask, Out_Of_Bounds
    );
    modport slave (
        input  Start, Next_X, Next_Y, X1, X2, X3, X4, Y1, Y2, Y3, Y4,
        output Busy, Result_Valid, Move_OK, Hit_Mask, Out_Of_Bounds
    );
endinterface

// File: rtl/rect_overlap.sv
// rect_overlap: inclusive-edge rectangle intersection in 11-bit math so x+w never wraps
module rect_overlap
    import wall_pkg::*;
(
    input  wall_rect_t a_i,
    input  wall_rect_t b_i,
    output logic       hit_o
);
    assign hit_o = (11'(a_i.x) <= 11'(b_i.x) + 11'(b_i.w)) &&
                   (11'(b_i.x) <= 11'(a_i.x) + 11'(a_i.w)) &&
                   (11'(a_i.y) <= 11'(b_i.y) + 11'(b_i.h)) &&
                   (11'(b_i.y) <= 11'(a_i.y) + 11'(a_i.h));
endmodule

// File: rtl/wall_collision.sv
// wall_collision: checks a proposed sprite position against four walls, one wall per clock
module wall_collision
    import wall_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    wall_collision_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0] state_q, state_d, idx_q, idx_d;
    logic [NUM_WALLS-1:0] acc_q, acc_d, hit_q;
    logic bnd_q, bnd_d, rv_q, ok_q, oob_q, hit, go;
    coord_t sx_q, sy_q;
    coord_t wx_q [NUM_WALLS];
    coord_t wy_q [NUM_WALLS];
    wall_rect_t obj, wall;

    assign go  = (state_q == IDLE) && bus.Start;
    assign obj = '{x: sx_q, y: sy_q, w: OBJ_SIZE, h: OBJ_SIZE};

    // current wall under test, selected by idx
    always_comb begin
        wall   = wall_dims(idx_q);
        wall.x = wx_q[idx_q];
        wall.y = wy_q[idx_q];
    end

    rect_overlap u_overlap (.a_i(obj), .b_i(wall), .hit_o(hit));

    // sequencer: accept request, step through walls, one DONE cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        bnd_d   = bnd_q;
        if (go) begin
            state_d = CHECK;
            idx_d   = '0;
            acc_d   = '0;
            bnd_d   = (11'(bus.Next_X) + 11'(OBJ_SIZE) > 11'(X_MAX)) ||
                      (11'(bus.Next_Y) + 11'(OBJ_SIZE) > 11'(Y_MAX));
        end else if (state_q == CHECK) begin
            acc_d[idx_q] = acc_q[idx_q] | hit;
            idx_d        = idx_q + 2'd1;
            state_d      = (idx_q == 2'd3) ? DONE : CHECK;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // sequencer state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            bnd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            bnd_q   <= bnd_d;
        end
    end

    // snapshot of sprite and wall coordinates taken on an accepted request
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_q <= '0;
            sy_q <= '0;
            wx_q <= '{default: '0};
            wy_q <= '{default: '0};
        end else if (go) begin
            sx_q <= bus.Next_X;
            sy_q <= bus.Next_Y;
            wx_q <= '{bus.X1, bus.X2, bus.X3, bus.X4};
            wy_q <= '{bus.Y1, bus.Y2, bus.Y3, bus.Y4};
        end
    end

    // published results, updated only when leaving DONE and held until the next one
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rv_q  <= 1'b0;
            hit_q <= '0;
            oob_q <= 1'b0;
            ok_q  <= 1'b0;
        end else begin
            rv_q <= (state_q == DONE);
            if (state_q == DONE) begin
                hit_q <= acc_q;
                oob_q <= bnd_q;
                ok_q  <= (acc_q == '0) && !bnd_q;
            end
        end
    end

    assign bus.Busy          = (state_q != IDLE);
    assign bus.Result_Valid  = rv_q;
    assign bus.Hit_Mask      = hit_q;
    assign bus.Out_Of_Bounds = oob_q;
    assign bus.Move_OK       = ok_q;
endmodule

// File: tb/tb_wall_collision.sv
// tb_wall_collision: directed-vector bench for the wall collision checker
module tb_wall_collision;
    import wall_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    wall_collision_if bus ();

    wall_collision dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input coord_t x, input coord_t y,
                       input logic [3:0] em, input logic eok, input logic eoob, input logic poke);
        int lat;
        int busy_n;
        @(negedge Clk);
        bus.Next_X = x;
        bus.Next_Y = y;
        bus.Start  = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        if (poke) bus.X1 = 10'd200;
        lat = 0;
        busy_n = 0;
        while (!bus.Result_Valid && lat < 12) begin
            if (bus.Busy) busy_n++;
            @(posedge Clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 5);
        check({tag, "_busy"}, busy_n, 5);
        check({tag, "_mask"}, bus.Hit_Mask, em);
        check({tag, "_ok"}, bus.Move_OK, eok);
        check({tag, "_oob"}, bus.Out_Of_Bounds, eoob);
        @(posedge Clk);
        #1;
        check({tag, "_pulse"}, bus.Result_Valid, 0);
        check({tag, "_hold"}, bus.Hit_Mask, em);
        bus.X1 = 10'd10;
    endtask

    initial begin
        int rv_n;
        logic [3:0] m;
        logic ok;
        bus.Start = 1'b0;
        bus.Next_X = '0;
        bus.Next_Y = '0;
        bus.X1 = 10'd10;  bus.X2 = 10'd400; bus.X3 = 10'd320; bus.X4 = 10'd600;
        bus.Y1 = 10'd20;  bus.Y2 = 10'd200; bus.Y3 = 10'd240; bus.Y4 = 10'd400;
        #2 Reset_n = 1'b0;
        #2;
        check("rst_busy", bus.Busy, 0);
        check("rst_rv", bus.Result_Valid, 0);
        check("rst_ok", bus.Move_OK, 0);
        check("rst_mask", bus.Hit_Mask, 0);
        check("rst_oob", bus.Out_Of_Bounds, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        run("clear",   10'd100, 10'd100, 4'b0000, 1'b1, 1'b0, 1'b0);
        run("corner1", 10'd74,  10'd52,  4'b0001, 1'b0, 1'b0, 1'b0);
        run("edge1",   10'd75,  10'd30,  4'b0000, 1'b1, 1'b0, 1'b0);
        run("w23",     10'd384, 10'd240, 4'b0110, 1'b0, 1'b0, 1'b0);
        run("oob",     10'd630, 10'd100, 4'b0000, 1'b0, 1'b1, 1'b0);
        run("limit",   10'd623, 10'd463, 4'b1000, 1'b0, 1'b0, 1'b0);
        run("poke_x1", 10'd74,  10'd52,  4'b0001, 1'b0, 1'b0, 1'b1);

        @(negedge Clk);
        bus.Next_X = 10'd100;
        bus.Next_Y = 10'd100;
        bus.Start  = 1'b1;
        @(negedge Clk);
        bus.Start  = 1'b0;
        @(negedge Clk);
        bus.Next_X = 10'd74;
        bus.Next_Y = 10'd52;
        bus.Start  = 1'b1;
        @(negedge Clk);
        bus.Start  = 1'b0;
        rv_n = 0;
        m = 4'hf;
        ok = 1'b0;
        repeat (12) begin
            @(posedge Clk);
            #1;
            if (bus.Result_Valid) begin
                rv_n++;
                m = bus.Hit_Mask;
                ok = bus.Move_OK;
            end
        end
        check("dbl_count", rv_n, 1);
        check("dbl_mask", m, 4'b0000);
        check("dbl_ok", ok, 1'b1);

        @(negedge Clk);
        bus.Next_X = 10'd384;
        bus.Next_Y = 10'd240;
        bus.Start  = 1'b1;
        @(negedge Clk);
        bus.Start  = 1'b0;
        repeat (8) @(negedge Clk);
        check("pre_rst_mask", bus.Hit_Mask, 4'b0110);
        @(negedge Clk);
        bus.Next_X = 10'd100;
        bus.Next_Y = 10'd100;
        bus.Start  = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        check("mid_busy", bus.Busy, 0);
        check("mid_rv", bus.Result_Valid, 0);
        check("mid_ok", bus.Move_OK, 0);
        check("mid_mask", bus.Hit_Mask, 0);
        check("mid_oob", bus.Out_Of_Bounds, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        rv_n = 0;
        repeat (8) begin
            @(posedge Clk);
            #1;
            if (bus.Result_Valid) rv_n++;
        end
        check("post_rst_rv", rv_n, 0);
        run("fresh", 10'd100, 10'd100, 4'b0000, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wall_collision.md
Name: wall_collision

Overview:
- Consumer side of the wall geometry interface: takes the four wall origins published by the wall generator and a proposed next position for a square sprite (tank/player).
- Runs a small sequential check, one wall per clock, and reports whether the move is legal, which walls were hit, and whether the sprite leaves the screen.
- Sits between the motion logic (which proposes Next_X/Next_Y once per frame) and the sprite position register (which commits only when Move_OK=1).

Parameters:
- OBJ_SIZE, 10'd16: sprite extent; sprite occupies X..X+OBJ_SIZE inclusive in each axis.
- HOR_W, 10'd64: width of horizontal walls (walls 1, 3).
- HOR_H, 10'd32: height of horizontal walls.
- VERT_W, 10'd32: width of vertical walls (walls 2, 4).
- VERT_H, 10'd64: height of vertical walls.
- X_MAX, 10'd639: rightmost legal pixel.
- Y_MAX, 10'd479: bottommost legal pixel.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  single-cycle request; sampled only in IDLE
- Next_X  in  10  proposed sprite top-left X; latched on accepted Start
- Next_Y  in  10  proposed sprite top-left Y; latched on accepted Start
- X1, X2, X3, X4  in  10 each  wall origins (top-left X); latched on accepted Start
- Y1, Y2, Y3, Y4  in  10 each  wall origins (top-left Y); latched on accepted Start
- Busy  out  1  high while a check is in progress
- Result_Valid  out  1  one-cycle pulse when results update
- Move_OK  out  1  1 = no wall hit and in bounds
- Hit_Mask  out  4  bit i-1 set if wall i overlaps the sprite
- Out_Of_Bounds  out  1  sprite extent exceeds X_MAX or Y_MAX

Behaviour:
- Reset (asynchronous, Reset_n=0): state=IDLE; Busy, Result_Valid, Move_OK, Hit_Mask, Out_Of_Bounds and the wall index all go to 0 immediately. Same behaviour if reset asserts mid-check; the partial result is discarded.
- States: IDLE, CHECK, DONE.
- IDLE: on Start=1 at a clock edge:
  - latch Next_X/Y and all eight wall coordinates;
  - clear the working hit accumulator and set idx=0;
  - compute the bounds flag: (Next_X+OBJ_SIZE > X_MAX) or (Next_Y+OBJ_SIZE > Y_MAX);
  - go to CHECK; Busy=1 from the next cycle.
- CHECK:
  - each cycle tests wall idx against the latched sprite and ORs the result into accumulator bit idx;
  - walls 0 and 2 use HOR_W/HOR_H; walls 1 and 3 use VERT_W/VERT_H;
  - idx increments; after idx=3, go to DONE.
  - CHECK lasts exactly 4 cycles.
- DONE (1 cycle):
  - register Hit_Mask=accumulator, Out_Of_Bounds=bounds flag, Move_OK = (accumulator==0) && !bounds;
  - pulse Result_Valid=1 and drop Busy;
  - return to IDLE.
- Latency: Result_Valid is high 5 clocks after the edge that samples Start. New outputs are visible in that same cycle and held stable until the next DONE.
- Start while Busy=1 (CHECK or DONE) is ignored; it is neither queued nor counted. Start in the same cycle as DONE is also ignored.
- Overlap test, inclusive on both ends, matching the renderer convention:
  - ox <= wx+ww and wx <= ox+OBJ_SIZE and oy <= wy+wh and wy <= oy+OBJ_SIZE.
- Width rules: all sums are computed in 11-bit unsigned so X+size never wraps. Latched coordinates and comparisons are unsigned; no negative values exist.
- Wall inputs may change at any time; only the values latched at Start matter.

Decomposition:
- Package wall_pkg contains:
  - X_MAX, Y_MAX;
  - HOR_W/HOR_H, VERT_W/VERT_H;
  - NUM_WALLS=4;
  - typedef coord_t (logic [9:0]);
  - struct wall_rect_t {x, y, w, h};
  - function wall_dims(idx) returning orientation-dependent w/h.
- The wall generator also imports this package, so wall dimensions are single-sourced.
- One combinational sub-module, rect_overlap, takes two rectangles and returns overlap using 11-bit math. It is instantiated once and muxed by idx.

Test Plan:
Common setup: walls X1..X4=10,400,320,600 and Y1..Y4=20,200,240,400; OBJ_SIZE=16.
- Start with Next=(100,100) -> Result_Valid exactly 5 clocks later; Move_OK=1, Hit_Mask=0000, Out_Of_Bounds=0; Busy high for 5 cycles.
- Next=(74,52), corner touching wall 1 at (74,52) -> Hit_Mask=0001, Move_OK=0. Next=(75,30) -> Hit_Mask=0000, Move_OK=1 (edge just clear).
- Next=(384,240), overlapping wall 3 and wall 2 on inclusive edges -> Hit_Mask=0110, Move_OK=0.
- Next=(630,100) (630+16=646>639) -> Out_Of_Bounds=1, Hit_Mask=0000, Move_OK=0. Next=(623,463) -> Out_Of_Bounds=0 (exact limit).
- Second Start pulsed 2 cycles after the first -> ignored; exactly one Result_Valid, and results reflect the first request. Change X1 during CHECK -> result unchanged.
- Assert Reset_n=0 during CHECK cycle 2 -> all outputs 0 asynchronously, no Result_Valid. After release, a fresh Start completes normally in 5 cycles.
